// File: rtl/weapon_pkg.sv
// Shared types and helpers for the archer weapon subsystem: aim sectors, slot states and the
// per-sector motion step.
package weapon_pkg;

    localparam logic [1:0] ARCHER = 2'b10;

    // 0 = East, counter-clockwise in 45 degree steps (2 = North, screen y decreasing).
    typedef enum logic [2:0] {
        SecE  = 3'd0,
        SecNe = 3'd1,
        SecN  = 3'd2,
        SecNw = 3'd3,
        SecW  = 3'd4,
        SecSw = 3'd5,
        SecS  = 3'd6,
        SecSe = 3'd7
    } sector_t;

    typedef logic slot_state_t;
    localparam slot_state_t SlotIdle   = 1'b0;
    localparam slot_state_t SlotFlying = 1'b1;

    typedef struct packed {
        logic signed [13:0] dx;
        logic signed [13:0] dy;
    } step_t;

    // Screen-space step; diagonals use roughly speed/sqrt(2) per axis.
    function automatic step_t step_of(sector_t sec, int speed);
        step_t st;
        int    diag;
        diag = (speed * 3) >>> 2;
        case (sec)
            SecE:    begin st.dx = 14'(speed);  st.dy = 14'(0);      end
            SecNe:   begin st.dx = 14'(diag);   st.dy = 14'(-diag);  end
            SecN:    begin st.dx = 14'(0);      st.dy = 14'(-speed); end
            SecNw:   begin st.dx = 14'(-diag);  st.dy = 14'(-diag);  end
            SecW:    begin st.dx = 14'(-speed); st.dy = 14'(0);      end
            SecSw:   begin st.dx = 14'(-diag);  st.dy = 14'(diag);   end
            SecS:    begin st.dx = 14'(0);      st.dy = 14'(speed);  end
            default: begin st.dx = 14'(diag);   st.dy = 14'(diag);   end
        endcase
        return st;
    endfunction

endpackage

// File: rtl/projectile_aim_sector.sv
// Combinational 8-way aim quantiser: picks the 45 degree sector from muzzle toward the target.
module projectile_aim_sector
    import weapon_pkg::*;
(
    input  logic [11:0] origin_x_i,
    input  logic [11:0] origin_y_i,
    input  logic [11:0] target_x_i,
    input  logic [11:0] target_y_i,
    output sector_t     sector_o
);

    logic signed [12:0] dx, dy;
    logic        [12:0] ax, ay;

    assign dx = $signed({1'b0, target_x_i}) - $signed({1'b0, origin_x_i});
    assign dy = $signed({1'b0, origin_y_i}) - $signed({1'b0, target_y_i});
    assign ax = dx[12] ? 13'(-dx) : 13'(dx);
    assign ay = dy[12] ? 13'(-dy) : 13'(dy);

    // Axis wins when it dominates the other by 2:1; dx = dy = 0 falls into East.
    always_comb begin
        sector_o = SecE;
        if ({1'b0, ax} >= {ay, 1'b0}) begin
            sector_o = dx[12] ? SecW : SecE;
        end else if ({1'b0, ay} >= {ax, 1'b0}) begin
            sector_o = dy[12] ? SecS : SecN;
        end else if (!dx[12]) begin
            sector_o = dy[12] ? SecSe : SecNe;
        end else begin
            sector_o = dy[12] ? SecSw : SecNw;
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Archer projectile pool: slot allocation on click, per-frame motion, edge despawn and boss hits.
module projectile_pool
    import weapon_pkg::*;
#(
    parameter int unsigned PROJ_COUNT      = 4,
    parameter int unsigned SPEED           = 8,
    parameter int unsigned COOLDOWN_FRAMES = 15,
    parameter int unsigned X_MAX           = 1023,
    parameter int unsigned Y_MAX           = 767,
    parameter int unsigned BOSS_W          = 128,
    parameter int unsigned BOSS_H          = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      frame_tick_i,
    input  logic [1:0]                game_active_i,
    input  logic [1:0]                char_class_i,
    input  logic                      mouse_clicked_i,
    input  logic [11:0]               origin_x_i,
    input  logic [11:0]               origin_y_i,
    input  logic [11:0]               xpos_mouse_ctl_i,
    input  logic [11:0]               ypos_mouse_ctl_i,
    input  logic [11:0]               boss_x_i,
    input  logic [11:0]               boss_y_i,
    input  logic                      boss_alive_i,
    output logic [12*PROJ_COUNT-1:0]  pos_x_proj_o,
    output logic [12*PROJ_COUNT-1:0]  pos_y_proj_o,
    output logic [PROJ_COUNT-1:0]     projectile_animated_o,
    output logic [3*PROJ_COUNT-1:0]   proj_sector_o,
    output logic                      projectile_hit_o,
    output logic [7:0]                hit_count_o
);

    localparam logic signed [13:0] XMax  = 14'(X_MAX);
    localparam logic signed [13:0] YMax  = 14'(Y_MAX);
    localparam logic signed [13:0] BossW = 14'(BOSS_W);
    localparam logic signed [13:0] BossH = 14'(BOSS_H);

    logic                  mouse_q;
    logic [15:0]           cooldown_q, cooldown_d;
    logic                  hit_q, hit_d;
    logic [7:0]            hit_count_q, hit_count_d;
    logic [8:0]            hit_sum;
    logic [PROJ_COUNT-1:0] flying, hits, alloc_oh;
    logic                  active, fire, free_found;
    logic signed [13:0]    box_x0, box_x1, box_y0, box_y1;
    sector_t               aim_sector;

    projectile_aim_sector u_aim (
        .origin_x_i (origin_x_i),
        .origin_y_i (origin_y_i),
        .target_x_i (xpos_mouse_ctl_i),
        .target_y_i (ypos_mouse_ctl_i),
        .sector_o   (aim_sector)
    );

    assign active = game_active_i != 2'b00;
    assign fire   = mouse_clicked_i & ~mouse_q & active & (char_class_i == ARCHER)
                  & (cooldown_q == '0) & ~(&flying);

    assign box_x0 = $signed({2'b00, boss_x_i});
    assign box_y0 = $signed({2'b00, boss_y_i});
    assign box_x1 = box_x0 + BossW;
    assign box_y1 = box_y0 + BossH;

    // Lowest-index idle slot; idleness is judged before this cycle's tick.
    always_comb begin
        alloc_oh   = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(PROJ_COUNT); i++) begin
            if (fire && !free_found && !flying[i]) begin
                alloc_oh[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < PROJ_COUNT; g++) begin : g_slot
        slot_state_t        state_q, state_d;
        logic [11:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
        sector_t            sector_q, sector_d;
        step_t              stp;
        logic signed [13:0] nx, ny;
        logic               off_screen, in_box;

        assign stp        = step_of(sector_q, int'(SPEED));
        assign nx         = $signed({2'b00, pos_x_q}) + $signed(stp.dx);
        assign ny         = $signed({2'b00, pos_y_q}) + $signed(stp.dy);
        assign off_screen = nx[13] || ny[13] || (nx > XMax) || (ny > YMax);
        assign in_box     = boss_alive_i && (nx >= box_x0) && (nx < box_x1)
                          && (ny >= box_y0) && (ny < box_y1);
        assign flying[g]  = state_q == SlotFlying;
        assign hits[g]    = frame_tick_i && flying[g] && !off_screen && in_box;

        always_comb begin
            state_d  = state_q;
            pos_x_d  = pos_x_q;
            pos_y_d  = pos_y_q;
            sector_d = sector_q;
            if (!active) begin
                state_d  = SlotIdle;
                pos_x_d  = '0;
                pos_y_d  = '0;
                sector_d = SecE;
            end else begin
                if (frame_tick_i && flying[g]) begin
                    if (off_screen || hits[g]) begin
                        state_d = SlotIdle;
                    end else begin
                        pos_x_d = nx[11:0];
                        pos_y_d = ny[11:0];
                    end
                end
                if (alloc_oh[g]) begin
                    state_d  = SlotFlying;
                    pos_x_d  = origin_x_i;
                    pos_y_d  = origin_y_i;
                    sector_d = aim_sector;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= SlotIdle;
                pos_x_q  <= '0;
                pos_y_q  <= '0;
                sector_q <= SecE;
            end else begin
                state_q  <= state_d;
                pos_x_q  <= pos_x_d;
                pos_y_q  <= pos_y_d;
                sector_q <= sector_d;
            end
        end

        assign pos_x_proj_o[12*g +: 12] = pos_x_q;
        assign pos_y_proj_o[12*g +: 12] = pos_y_q;
        assign proj_sector_o[3*g +: 3]  = sector_q;
    end

    always_comb begin
        cooldown_d  = cooldown_q;
        hit_d       = 1'b0;
        hit_count_d = hit_count_q;
        hit_sum     = '0;
        if (!active) begin
            cooldown_d  = '0;
            hit_count_d = '0;
        end else begin
            if (frame_tick_i) begin
                if (cooldown_q != '0) cooldown_d = cooldown_q - 16'd1;
                hit_d       = |hits;
                hit_sum     = {1'b0, hit_count_q} + 9'($countones(hits));
                hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];
            end
            if (fire) cooldown_d = 16'(COOLDOWN_FRAMES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mouse_q     <= 1'b0;
            cooldown_q  <= '0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            mouse_q     <= mouse_clicked_i;
            cooldown_q  <= cooldown_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign projectile_animated_o = flying;
    assign projectile_hit_o      = hit_q;
    assign hit_count_o           = hit_count_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a behavioural model of the pool.
module tb_projectile_pool;

    localparam int P    = 4;
    localparam int SPD  = 8;
    localparam int DIAG = (SPD * 3) / 4;
    localparam int CD   = 15;
    localparam int XMAX = 1023;
    localparam int YMAX = 767;
    localparam int BW   = 128;
    localparam int BH   = 128;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            frame_tick = 1'b0;
    logic [1:0]      game_active = 2'b01;
    logic [1:0]      char_class = 2'b10;
    logic            mouse_clicked = 1'b0;
    logic [11:0]     origin_x = '0, origin_y = '0, mouse_x = '0, mouse_y = '0;
    logic [11:0]     boss_x = 12'd600, boss_y = 12'd250;
    logic            boss_alive = 1'b0;
    logic [12*P-1:0] pos_x, pos_y;
    logic [P-1:0]    animated;
    logic [3*P-1:0]  sector;
    logic            proj_hit;
    logic [7:0]      hit_count;

    int n_checks = 0;
    int n_errors = 0;

    projectile_pool #(
        .PROJ_COUNT(P), .SPEED(SPD), .COOLDOWN_FRAMES(CD), .X_MAX(XMAX), .Y_MAX(YMAX),
        .BOSS_W(BW), .BOSS_H(BH)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .frame_tick_i          (frame_tick),
        .game_active_i         (game_active),
        .char_class_i          (char_class),
        .mouse_clicked_i       (mouse_clicked),
        .origin_x_i            (origin_x),
        .origin_y_i            (origin_y),
        .xpos_mouse_ctl_i      (mouse_x),
        .ypos_mouse_ctl_i      (mouse_y),
        .boss_x_i              (boss_x),
        .boss_y_i              (boss_y),
        .boss_alive_i          (boss_alive),
        .pos_x_proj_o          (pos_x),
        .pos_y_proj_o          (pos_y),
        .projectile_animated_o (animated),
        .proj_sector_o         (sector),
        .projectile_hit_o      (proj_hit),
        .hit_count_o           (hit_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int slot, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s slot %0d: got %0d, expected %0d (t=%0t)", name, slot, got, exp,
                     $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_x[P], m_y[P], m_sec[P];
    bit m_fly[P];
    int m_cd, m_hc;
    bit m_hit, m_mouse;

    const int step_x[8] = '{SPD, DIAG, 0, -DIAG, -SPD, -DIAG, 0, DIAG};
    const int step_y[8] = '{0, -DIAG, -SPD, -DIAG, 0, DIAG, SPD, DIAG};

    function automatic int aim(input int ox, input int oy, input int tx, input int ty);
        int dx, dy, ax, ay;
        dx = tx - ox;
        dy = oy - ty;
        ax = dx < 0 ? -dx : dx;
        ay = dy < 0 ? -dy : dy;
        if (ax >= 2 * ay) return dx < 0 ? 4 : 0;
        if (ay >= 2 * ax) return dy < 0 ? 6 : 2;
        if (dx > 0) return dy > 0 ? 1 : 7;
        return dy > 0 ? 3 : 5;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < P; i++) begin
                m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sec[i] = 0;
            end
            m_cd = 0; m_hc = 0; m_hit = 0; m_mouse = 0;
        end else begin
            int  free_idx, nh, nx, ny;
            bit  fire;
            free_idx = -1;
            for (int i = P - 1; i >= 0; i--) if (!m_fly[i]) free_idx = i;
            fire = mouse_clicked && !m_mouse && game_active != 0 && char_class == 2'b10
                   && m_cd == 0 && free_idx >= 0;
            m_mouse = mouse_clicked;
            if (game_active == 0) begin
                for (int i = 0; i < P; i++) m_fly[i] = 0;
                m_cd = 0; m_hc = 0; m_hit = 0;
            end else begin
                m_hit = 0;
                if (frame_tick) begin
                    nh = 0;
                    for (int i = 0; i < P; i++) begin
                        if (m_fly[i]) begin
                            nx = m_x[i] + step_x[m_sec[i]];
                            ny = m_y[i] + step_y[m_sec[i]];
                            if (nx < 0 || ny < 0 || nx > XMAX || ny > YMAX) begin
                                m_fly[i] = 0;
                            end else if (boss_alive && nx >= int'(boss_x)
                                         && nx < int'(boss_x) + BW && ny >= int'(boss_y)
                                         && ny < int'(boss_y) + BH) begin
                                m_fly[i] = 0;
                                nh++;
                            end else begin
                                m_x[i] = nx;
                                m_y[i] = ny;
                            end
                        end
                    end
                    if (m_cd > 0) m_cd--;
                    m_hit = nh > 0;
                    m_hc  = (m_hc + nh > 255) ? 255 : m_hc + nh;
                end
                if (fire) begin
                    m_fly[free_idx] = 1;
                    m_x[free_idx]   = int'(origin_x);
                    m_y[free_idx]   = int'(origin_y);
                    m_sec[free_idx] = aim(origin_x, origin_y, mouse_x, mouse_y);
                    m_cd = CD;
                end
            end
        end
    end

    // Compare process: every outputs-stable point (negedge).
    always @(negedge clk_i) begin
        for (int i = 0; i < P; i++) begin
            chk("animated", i, int'(animated[i]), int'(m_fly[i]));
            if (m_fly[i]) begin
                chk("pos_x", i, int'(pos_x[12*i +: 12]), m_x[i]);
                chk("pos_y", i, int'(pos_y[12*i +: 12]), m_y[i]);
                chk("sector", i, int'(sector[3*i +: 3]), m_sec[i]);
            end
        end
        chk("projectile_hit", -1, int'(proj_hit), int'(m_hit));
        chk("hit_count", -1, int'(hit_count), m_hc);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit tick, input bit click);
        frame_tick    = tick;
        mouse_clicked = click;
        @(posedge clk_i);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic aim_at(input int ox, input int oy, input int tx, input int ty);
        origin_x = 12'(ox); origin_y = 12'(oy); mouse_x = 12'(tx); mouse_y = 12'(ty);
    endtask

    task automatic clear_game();
        game_active = 2'b00;
        cyc(0, 0);
        chk("clear_animated", -1, int'(animated), 0);
        chk("clear_hit_count", -1, int'(hit_count), 0);
        game_active = 2'b01;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_animated", -1, int'(animated), 0);
        chk("reset_pos_x", -1, int'(pos_x == '0), 1);
        chk("reset_hit_count", -1, int'(hit_count), 0);
        chk("reset_hit", -1, int'(proj_hit), 0);
        rst_ni = 1'b1;

        // East shot, three frames of motion.
        aim_at(100, 300, 500, 300);
        cyc(0, 1);
        chk("fire_animated", 0, int'(animated), 1);
        chk("fire_pos_x", 0, int'(pos_x[11:0]), 100);
        chk("fire_pos_y", 0, int'(pos_y[11:0]), 300);
        chk("fire_sector", 0, int'(sector[2:0]), 0);
        cyc(0, 0);
        repeat (3) cyc(1, 0);
        chk("east_3tick_x", 0, int'(pos_x[11:0]), 124);
        // Still cooling down: click dropped.
        cyc(0, 1);
        cyc(0, 0);
        chk("cooldown_drop", -1, int'(animated), 1);
        clear_game();

        // North shot runs off the top edge.
        aim_at(400, 400, 400, 0);
        cyc(0, 1);
        cyc(0, 0);
        chk("north_sector", 0, int'(sector[2:0]), 2);
        repeat (50) cyc(1, 0);
        chk("north_y_zero", 0, int'(pos_y[11:0]), 0);
        chk("north_alive", 0, int'(animated[0]), 1);
        cyc(1, 0);
        chk("north_despawn", 0, int'(animated[0]), 0);

        // Dead boss: passes through.
        boss_alive = 1'b0;
        aim_at(610, 300, 1000, 300);
        cyc(0, 1);
        cyc(1, 0);
        chk("dead_boss_x", 0, int'(pos_x[11:0]), 618);
        chk("dead_boss_hit", -1, int'(proj_hit), 0);
        clear_game();

        // Two slots enter the boss box on the same frame.
        boss_alive = 1'b1;
        aim_at(400, 260, 1000, 260);
        cyc(0, 1);
        repeat (15) cyc(1, 0);
        aim_at(520, 300, 1000, 300);
        cyc(0, 1);
        chk("two_slots", -1, int'(animated), 3);
        repeat (9) cyc(1, 0);
        chk("pre_hit_x", 1, int'(pos_x[23:12]), 592);
        cyc(1, 0);
        chk("double_hit_pulse", -1, int'(proj_hit), 1);
        chk("double_hit_count", -1, int'(hit_count), 2);
        chk("double_hit_idle", -1, int'(animated), 0);
        cyc(0, 0);
        chk("hit_one_cycle", -1, int'(proj_hit), 0);
        clear_game();

        // Saturation: 256 single hits.
        aim_at(610, 300, 1000, 300);
        for (int k = 0; k < 256; k++) begin
            cyc(0, 1);
            repeat (15) cyc(1, 0);
        end
        chk("hit_count_sat", -1, int'(hit_count), 255);

        // Asynchronous reset mid-flight.
        aim_at(100, 300, 500, 300);
        cyc(0, 1);
        cyc(1, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_animated", -1, int'(animated), 0);
        chk("async_rst_hit_count", -1, int'(hit_count), 0);
        chk("async_rst_pos", -1, int'(pos_x == '0 && pos_y == '0), 1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Random phase.
        for (int k = 0; k < 4000; k++) begin
            game_active = ($urandom_range(0, 199) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            char_class  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            boss_alive  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) begin
                boss_x = 12'($urandom_range(0, 900));
                boss_y = 12'($urandom_range(0, 650));
            end
            aim_at($urandom_range(0, XMAX), $urandom_range(0, YMAX),
                   $urandom_range(0, XMAX), $urandom_range(0, YMAX));
            cyc($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        end

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
